// File: rtl/regbank_sb.sv
// Multi-read-port register bank with per-register pending (scoreboard) bits.
// Optional write-first forwarding on the read ports: define REGBANK_SB_BYPASS_EN.
module regbank_sb #(
   parameter  int NUMREGS   = 32,
   parameter  int DATAWIDTH = 32,
   parameter  int NUMRD     = 2,
   localparam int AW        = $clog2(NUMREGS)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUMRD-1:0]          re_i,
   input  logic [NUMRD*AW-1:0]       raddr_i,
   output logic [NUMRD*DATAWIDTH-1:0] rdata_o,
   output logic [NUMRD-1:0]          rbusy_o,
   input  logic                      we_i,
   input  logic [AW-1:0]             waddr_i,
   input  logic [DATAWIDTH-1:0]      wdata_i,
   input  logic                      alloc_i,
   input  logic [AW-1:0]             alloc_addr_i,
   output logic                      alloc_ready_o,
   output logic [NUMREGS-1:0]        busy_o
);

`ifdef REGBANK_SB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [DATAWIDTH-1:0] bank [NUMREGS];
   logic [NUMREGS-1:0]   pending, pend_nxt;
   logic                 wr_ok, alloc_in, alloc_ok;

   assign wr_ok    = we_i && (waddr_i != '0) && (32'(waddr_i) < NUMREGS);
   assign alloc_in = (alloc_addr_i != '0) && (32'(alloc_addr_i) < NUMREGS);

   // Ready looks only at registered pending: no path from we_i.
   assign alloc_ready_o = !alloc_i || !alloc_in || !pending[alloc_addr_i];
   assign alloc_ok      = alloc_i && alloc_ready_o && alloc_in;

   // Set after clear so a same-cycle new producer keeps the register pending.
   always_comb begin
      pend_nxt = pending;
      if (wr_ok)    pend_nxt[waddr_i]      = 1'b0;
      if (alloc_ok) pend_nxt[alloc_addr_i] = 1'b1;
      pend_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pending <= '0;
      else       pending <= pend_nxt;
   end

   assign busy_o = pending;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUMREGS; r++) bank[r] <= '0;
      end else if (wr_ok) begin
         bank[waddr_i] <= wdata_i;
      end
   end

   logic [DATAWIDTH-1:0] rdata_q [NUMRD];
   logic [NUMRD-1:0]     rbusy_q;

   for (genvar p = 0; p < NUMRD; p++) begin : g_rd
      logic [AW-1:0]        ra;
      logic                 ra_ok;
      logic [DATAWIDTH-1:0] rd_val;
      logic                 rb_val;

      assign ra    = raddr_i[p*AW +: AW];
      assign ra_ok = (ra != '0) && (32'(ra) < NUMREGS);

      always_comb begin
         rd_val = '0;
         rb_val = 1'b0;
         if (ra_ok) begin
            rb_val = pend_nxt[ra];
            if (BYPASS && wr_ok && (waddr_i == ra)) rd_val = wdata_i;
            else                                    rd_val = bank[ra];
         end
      end

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            rdata_q[p] <= '0;
            rbusy_q[p] <= 1'b0;
         end else if (re_i[p]) begin
            rdata_q[p] <= rd_val;
            rbusy_q[p] <= rb_val;
         end
      end

      assign rdata_o[p*DATAWIDTH +: DATAWIDTH] = rdata_q[p];
   end

   assign rbusy_o = rbusy_q;

endmodule
